// File: rtl/sched_pkg.sv
// Shared definitions for the enqueue dispatcher: FSM encoding, the default
// location of the dst_port byte in tuser, and the byte counter width.
package sched_pkg;

   // FSM encoding; 2'd3 is unused and recovers to IDLE
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_DROP  = 2'd2;

   // Bit position of the one-hot dst_port byte inside the SUME metadata
   localparam int SCHED_DST_PORT_LSB = 24;

   // Width of every byte counter and of the drop total
   localparam int BYTE_CNT_W = 32;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] value);
      return (&value) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/sched_keep_popcount.sv
// Counts the set bits of a tkeep vector, giving the valid byte count of a beat.
module sched_keep_popcount #(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]   keep,
   output logic [COUNT_W-1:0] count
);

   // Plain adder chain over the keep bits
   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + COUNT_W'(keep[i]);
      end
   end

endmodule

// File: rtl/sched_enqueue_dispatch_v0_2.sv
// Enqueue dispatcher: steers each AXIS packet into the output queues named by
// its dst_port byte, dropping it for queues that are nearly full or whose PIFO
// is full at the first beat. The admission decision is taken once per packet.
// Optional feature macro: SCHED_DROP_STATS_EN enables pkt_dropped,
// bytes_dropped and drop_total; without it they are constant 0.
module sched_enqueue_dispatch_v0_2
   import sched_pkg::*;
#(
   parameter int DATA_WIDTH           = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 160,
   parameter int NUM_QUEUES           = 5,
   parameter int DST_PORT_LSB         = SCHED_DST_PORT_LSB
) (
   input  logic                            axis_aclk,
   input  logic                            axis_resetn,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tlast,
   input  logic [DATA_WIDTH/8-1:0]         s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
   output logic                            s_axis_tready,
   input  logic [NUM_QUEUES-1:0]           buffer_almost_full,
   input  logic [NUM_QUEUES-1:0]           pifo_full,
   output logic [NUM_QUEUES-1:0]           buffer_wr_en,
   output logic [NUM_QUEUES-1:0]           pifo_insert_en,
   output logic [NUM_QUEUES-1:0]           pkt_stored,
   output logic [NUM_QUEUES-1:0]           pkt_dropped,
   output logic [BYTE_CNT_W-1:0]           bytes_stored,
   output logic [BYTE_CNT_W-1:0]           bytes_dropped,
   output logic [BYTE_CNT_W-1:0]           drop_total
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam int KCNT_W = $clog2(KEEP_W + 1);

   logic [1:0]            state;
   logic                  tready_q;
   logic                  beat;
   logic                  first_beat;
   logic                  pkt_done;
   logic [NUM_QUEUES-1:0] dst_mask;
   logic [NUM_QUEUES-1:0] elig_now;
   logic [NUM_QUEUES-1:0] elig_q;
   logic [NUM_QUEUES-1:0] cur_elig;
   logic [NUM_QUEUES-1:0] stored_q;
   logic [KCNT_W-1:0]     keep_count;
   logic [BYTE_CNT_W-1:0] byte_acc;
   logic [BYTE_CNT_W-1:0] byte_total;
   logic [BYTE_CNT_W-1:0] stat_bytes_q;
   logic                  unused_tuser;

   // Only the dst_port byte of tuser matters here
   assign unused_tuser = ^s_axis_tuser;

   sched_keep_popcount #(
      .WIDTH   (KEEP_W),
      .COUNT_W (KCNT_W)
   ) u_keep_popcount (
      .keep  (s_axis_tkeep),
      .count (keep_count)
   );

   // Queues keep a full packet of headroom, so the stream is never stalled;
   // ready is simply held low while in reset
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         tready_q <= 1'b0;
      end else begin
         tready_q <= 1'b1;
      end
   end

   assign s_axis_tready = tready_q;
   assign beat          = s_axis_tvalid & s_axis_tready;
   assign first_beat    = (state != ST_WRITE) && (state != ST_DROP);
   assign pkt_done      = beat & s_axis_tlast;

   // Even dst_port bits select the physical queues, any odd bit selects DMA
   always_comb begin
      dst_mask = '0;
      for (int i = 0; i < NUM_QUEUES - 1; i++) begin
         dst_mask[i] = s_axis_tuser[DST_PORT_LSB + 2*i];
      end
      dst_mask[NUM_QUEUES-1] = s_axis_tuser[DST_PORT_LSB + 1] | s_axis_tuser[DST_PORT_LSB + 3]
                             | s_axis_tuser[DST_PORT_LSB + 5] | s_axis_tuser[DST_PORT_LSB + 7];
   end

   assign elig_now   = dst_mask & ~buffer_almost_full & ~pifo_full;
   assign cur_elig   = first_beat ? elig_now : elig_q;
   assign byte_total = (first_beat ? '0 : byte_acc) + BYTE_CNT_W'(keep_count);

   // Write strobes follow the live decision on the first beat, the latched one after
   always_comb begin
      buffer_wr_en   = '0;
      pifo_insert_en = '0;
      if (beat) begin
         if (first_beat) begin
            buffer_wr_en   = elig_now;
            pifo_insert_en = elig_now;
         end else if (state == ST_WRITE) begin
            buffer_wr_en = elig_q;
         end
      end
   end

   // Packet FSM: decide on the first beat, hold that decision until tlast
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state    <= ST_IDLE;
         elig_q   <= '0;
         byte_acc <= '0;
      end else if (beat) begin
         byte_acc <= byte_total;
         if (first_beat) begin
            elig_q <= elig_now;
            if (!s_axis_tlast) begin
               state <= (|elig_now) ? ST_WRITE : ST_DROP;
            end else begin
               state <= ST_IDLE;
            end
         end else if (s_axis_tlast) begin
            state <= ST_IDLE;
         end
      end else if (first_beat) begin
         state <= ST_IDLE;
      end
   end

   // Stored pulse and packet byte count, registered one cycle after tlast
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         stored_q     <= '0;
         stat_bytes_q <= '0;
      end else begin
         stored_q     <= pkt_done ? cur_elig : '0;
         stat_bytes_q <= pkt_done ? byte_total : '0;
      end
   end

   assign pkt_stored   = stored_q;
   assign bytes_stored = (|stored_q) ? stat_bytes_q : '0;

`ifdef SCHED_DROP_STATS_EN
   logic [NUM_QUEUES-1:0] mask_q;
   logic [NUM_QUEUES-1:0] cur_mask;
   logic [NUM_QUEUES-1:0] drop_now;
   logic [NUM_QUEUES-1:0] dropped_q;
   logic [BYTE_CNT_W-1:0] drop_total_q;

   assign cur_mask = first_beat ? dst_mask : mask_q;
   assign drop_now = cur_mask & ~cur_elig;

   // Destination mask is kept so a partial multicast can report its dropped queues
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         mask_q <= '0;
      end else if (beat && first_beat) begin
         mask_q <= dst_mask;
      end
   end

   // Dropped pulse and saturating packet drop total
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         dropped_q    <= '0;
         drop_total_q <= '0;
      end else begin
         dropped_q <= pkt_done ? drop_now : '0;
         if (pkt_done && (|drop_now)) begin
            drop_total_q <= sat_inc(drop_total_q);
         end
      end
   end

   assign pkt_dropped   = dropped_q;
   assign bytes_dropped = (|dropped_q) ? stat_bytes_q : '0;
   assign drop_total    = drop_total_q;
`else
   assign pkt_dropped   = '0;
   assign bytes_dropped = '0;
   assign drop_total    = '0;
`endif

endmodule

// File: tb/tb_sched_enqueue_dispatch_v0_2.sv
// Self-checking bench for sched_enqueue_dispatch_v0_2 with a packet-level
// reference model (destination decode, admission, byte sums, drop total).
module tb_sched_enqueue_dispatch_v0_2;

`ifdef SCHED_DROP_STATS_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic         axis_aclk = 1'b0;
   logic         axis_resetn;
   logic         s_axis_tvalid;
   logic         s_axis_tlast;
   logic [31:0]  s_axis_tkeep;
   logic [159:0] s_axis_tuser;
   logic         s_axis_tready;
   logic [4:0]   buffer_almost_full;
   logic [4:0]   pifo_full;
   logic [4:0]   buffer_wr_en;
   logic [4:0]   pifo_insert_en;
   logic [4:0]   pkt_stored;
   logic [4:0]   pkt_dropped;
   logic [31:0]  bytes_stored;
   logic [31:0]  bytes_dropped;
   logic [31:0]  drop_total;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit          in_pkt = 1'b0;
   logic [4:0]  pkt_mask = '0;
   logic [4:0]  pkt_elig = '0;
   logic [31:0] pkt_bytes = '0;
   logic [4:0]  exp_stored = '0;
   logic [4:0]  exp_dropped = '0;
   logic [31:0] exp_bytes_st = '0;
   logic [31:0] exp_bytes_dr = '0;
   logic [31:0] exp_drop_total = '0;

   always #5 axis_aclk = ~axis_aclk;

   sched_enqueue_dispatch_v0_2 dut (
      .axis_aclk          (axis_aclk),
      .axis_resetn        (axis_resetn),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tlast       (s_axis_tlast),
      .s_axis_tkeep       (s_axis_tkeep),
      .s_axis_tuser       (s_axis_tuser),
      .s_axis_tready      (s_axis_tready),
      .buffer_almost_full (buffer_almost_full),
      .pifo_full          (pifo_full),
      .buffer_wr_en       (buffer_wr_en),
      .pifo_insert_en     (pifo_insert_en),
      .pkt_stored         (pkt_stored),
      .pkt_dropped        (pkt_dropped),
      .bytes_stored       (bytes_stored),
      .bytes_dropped      (bytes_dropped),
      .drop_total         (drop_total)
   );

   function automatic logic [4:0] dst_to_mask(input logic [7:0] dst);
      logic [4:0] m;
      for (int i = 0; i < 4; i++) m[i] = dst[2*i];
      m[4] = |(dst & 8'hAA);
      return m;
   endfunction

   function automatic logic [159:0] rand_tuser(input logic [7:0] dst);
      logic [159:0] u;
      for (int w = 0; w < 5; w++) u[w*32 +: 32] = $urandom;
      u[31:24] = dst;
      return u;
   endfunction

   // Drives one clock of stimulus, checks every output against the model, then advances it
   task automatic cycle(input logic v, input logic l, input logic [31:0] k,
                        input logic [159:0] u, input logic [4:0] baf, input logic [4:0] pf);
      logic [4:0] e_wr;
      logic [4:0] e_pifo;
      @(negedge axis_aclk);
      s_axis_tvalid = v; s_axis_tlast = l; s_axis_tkeep = k; s_axis_tuser = u;
      buffer_almost_full = baf; pifo_full = pf;
      #2;
      e_wr = '0; e_pifo = '0;
      if (v) begin
         if (!in_pkt) begin
            pkt_mask  = dst_to_mask(u[31:24]);
            pkt_elig  = pkt_mask & ~baf & ~pf;
            pkt_bytes = '0;
            e_pifo    = pkt_elig;
         end
         e_wr = pkt_elig;
         pkt_bytes = pkt_bytes + 32'($countones(k));
      end
      n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("[TB] FAIL tready: got %b expected 1", s_axis_tready); end
      n_cmp++; if (buffer_wr_en !== e_wr) begin n_err++; $display("[TB] FAIL wr_en: got %b expected %b", buffer_wr_en, e_wr); end
      n_cmp++; if (pifo_insert_en !== e_pifo) begin n_err++; $display("[TB] FAIL pifo_insert: got %b expected %b", pifo_insert_en, e_pifo); end
      n_cmp++; if (pkt_stored !== exp_stored) begin n_err++; $display("[TB] FAIL pkt_stored: got %b expected %b", pkt_stored, exp_stored); end
      n_cmp++; if (bytes_stored !== exp_bytes_st) begin n_err++; $display("[TB] FAIL bytes_stored: got %0d expected %0d", bytes_stored, exp_bytes_st); end
      n_cmp++; if (pkt_dropped !== exp_dropped) begin n_err++; $display("[TB] FAIL pkt_dropped: got %b expected %b", pkt_dropped, exp_dropped); end
      n_cmp++; if (bytes_dropped !== exp_bytes_dr) begin n_err++; $display("[TB] FAIL bytes_dropped: got %0d expected %0d", bytes_dropped, exp_bytes_dr); end
      n_cmp++; if (drop_total !== exp_drop_total) begin n_err++; $display("[TB] FAIL drop_total: got %h expected %h", drop_total, exp_drop_total); end
      exp_stored = '0; exp_dropped = '0; exp_bytes_st = '0; exp_bytes_dr = '0;
      if (v && l) begin
         exp_stored = pkt_elig;
         if (DROP_EN) exp_dropped = pkt_mask & ~pkt_elig;
         exp_bytes_st = (exp_stored != '0) ? pkt_bytes : '0;
         exp_bytes_dr = (exp_dropped != '0) ? pkt_bytes : '0;
         if (exp_dropped != '0 && exp_drop_total != 32'hFFFF_FFFF) exp_drop_total = exp_drop_total + 1;
         in_pkt = 1'b0;
      end else if (v) begin
         in_pkt = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   // One packet; noisy adds bubbles, later-beat status/dst churn and random tlast on bubbles
   task automatic send_packet(input logic [7:0] dst, input int nbeats, input logic [31:0] last_keep,
                              input logic [4:0] baf, input logic [4:0] pf, input bit noisy);
      for (int b = 0; b < nbeats; b++) begin
         logic [31:0] k;
         logic [4:0]  sb;
         logic [4:0]  sp;
         logic [7:0]  d;
         if (noisy && b > 0 && $urandom_range(0, 3) == 0)
            cycle(1'b0, 1'($urandom), 32'($urandom), rand_tuser(8'($urandom)), 5'($urandom), 5'($urandom));
         k  = (b == nbeats - 1) ? last_keep : 32'hFFFF_FFFF;
         sb = (b == 0 || !noisy) ? baf : 5'($urandom);
         sp = (b == 0 || !noisy) ? pf  : 5'($urandom);
         d  = (b == 0 || !noisy) ? dst : 8'($urandom);
         cycle(1'b1, 1'(b == nbeats - 1), k, rand_tuser(d), sb, sp);
      end
   endtask

   task automatic test_reset;
      axis_resetn = 1'b0;
      s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tkeep = '1;
      s_axis_tuser = rand_tuser(8'hFF); buffer_almost_full = '0; pifo_full = '0;
      repeat (3) @(negedge axis_aclk);
      #2;
      n_cmp++;
      if ({s_axis_tready, buffer_wr_en, pifo_insert_en, pkt_stored, pkt_dropped,
           bytes_stored, bytes_dropped, drop_total} !== '0) begin
         n_err++; $display("[TB] FAIL reset_outputs: got ready=%b wr=%b pifo=%b stored=%b total=%h expected all 0",
                           s_axis_tready, buffer_wr_en, pifo_insert_en, pkt_stored, drop_total);
      end
      @(negedge axis_aclk);
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      axis_resetn = 1'b1;
      idle(2);
   endtask

   task automatic test_unicast;
      send_packet(8'h04, 3, 32'hFFFF_FFFF, 5'b00000, 5'b00000, 1'b0);
      idle(2);
   endtask

   task automatic test_drop_full;
      send_packet(8'h01, 2, 32'hFFFF_FFFF, 5'b00001, 5'b00000, 1'b0);
      idle(2);
   endtask

   task automatic test_partial_multicast;
      send_packet(8'h05, 2, 32'h0000_00FF, 5'b00000, 5'b00010, 1'b0);
      idle(2);
   endtask

   task automatic test_dma_partial_keep;
      send_packet(8'h02, 4, 32'h0000_FFFF, 5'b00000, 5'b00000, 1'b0);
      idle(2);
   endtask

   task automatic test_single_beat;
      send_packet(8'h10, 1, 32'h0000_000F, 5'b00000, 5'b00000, 1'b0);
      send_packet(8'h80, 1, 32'hFFFF_FFFF, 5'b10000, 5'b00000, 1'b0);
      idle(2);
   endtask

   task automatic test_zero_mask;
      send_packet(8'h00, 3, 32'hFFFF_FFFF, 5'b00000, 5'b00000, 1'b0);
      send_packet(8'h00, 1, 32'h0000_0001, 5'b00000, 5'b00000, 1'b0);
      idle(2);
   endtask

   task automatic test_mid_status;
      cycle(1'b1, 1'b0, 32'hFFFF_FFFF, rand_tuser(8'h04), 5'b00000, 5'b00000);
      for (int b = 0; b < 3; b++)
         cycle(1'b1, 1'b0, 32'hFFFF_FFFF, rand_tuser(8'h00), 5'b11111, 5'b11111);
      cycle(1'b1, 1'b1, 32'h0000_0003, rand_tuser(8'h00), 5'b11111, 5'b11111);
      idle(2);
   endtask

   task automatic test_mid_reset;
      cycle(1'b1, 1'b0, 32'hFFFF_FFFF, rand_tuser(8'h01), 5'b00001, 5'b00000);
      cycle(1'b1, 1'b0, 32'hFFFF_FFFF, rand_tuser(8'h01), 5'b00000, 5'b00000);
      @(negedge axis_aclk);
      axis_resetn = 1'b0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
      #2;
      n_cmp++;
      if ({s_axis_tready, buffer_wr_en, pifo_insert_en, pkt_stored, pkt_dropped,
           bytes_stored, bytes_dropped, drop_total} !== '0) begin
         n_err++; $display("[TB] FAIL mid_reset_outputs: got ready=%b wr=%b pifo=%b dropped=%b total=%h expected all 0",
                           s_axis_tready, buffer_wr_en, pifo_insert_en, pkt_dropped, drop_total);
      end
      @(negedge axis_aclk);
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      axis_resetn = 1'b1;
      in_pkt = 1'b0;
      exp_stored = '0; exp_dropped = '0; exp_bytes_st = '0; exp_bytes_dr = '0;
      exp_drop_total = '0;
      idle(2);
      send_packet(8'h08, 3, 32'h0000_0FFF, 5'b00000, 5'b00000, 1'b0);
      idle(2);
   endtask

   task automatic test_back_to_back;
      send_packet(8'h04, 2, 32'hFFFF_FFFF, 5'b00000, 5'b00000, 1'b0);
      send_packet(8'h01, 1, 32'h0000_00FF, 5'b00001, 5'b00000, 1'b0);
      send_packet(8'h55, 3, 32'h0000_0001, 5'b00100, 5'b00010, 1'b0);
      send_packet(8'hAA, 2, 32'hF000_0000, 5'b00000, 5'b00000, 1'b0);
      send_packet(8'h00, 1, 32'hFFFF_FFFF, 5'b00000, 5'b00000, 1'b0);
      send_packet(8'h40, 2, 32'h0F0F_0F0F, 5'b01000, 5'b00000, 1'b0);
      idle(2);
   endtask

   task automatic test_random;
      for (int p = 0; p < 60; p++) begin
         logic [7:0] dst;
         dst = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         send_packet(dst, $urandom_range(1, 5), 32'($urandom),
                     5'($urandom & $urandom), 5'($urandom & $urandom & $urandom), 1'b1);
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(2);
   endtask

   task automatic test_saturation;
`ifdef SCHED_DROP_STATS_EN
      @(negedge axis_aclk);
      force dut.drop_total_q = 32'hFFFF_FFFF;
      @(negedge axis_aclk);
      release dut.drop_total_q;
      exp_drop_total = 32'hFFFF_FFFF;
`endif
      send_packet(8'h01, 2, 32'hFFFF_FFFF, 5'b00001, 5'b00000, 1'b0);
      send_packet(8'h03, 1, 32'h0000_FFFF, 5'b10001, 5'b00000, 1'b0);
      idle(2);
   endtask

   initial begin
      $display("[TB] start, drop stats %s", DROP_EN ? "enabled" : "disabled");
      test_reset;
      test_unicast;
      test_drop_full;
      test_partial_multicast;
      test_dma_partial_keep;
      test_single_beat;
      test_zero_mask;
      test_mid_status;
      test_mid_reset;
      test_back_to_back;
      test_random;
      test_saturation;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
